// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth sequential multiplier: controller states
// and the recoded digit produced by the encoder.
package booth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Digit in {-2,-1,0,+1,+2} as sign, magnitude-doubling and zero flags.
  typedef struct packed {
    logic neg;
    logic dbl;
    logic zero;
  } booth_digit_t;

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window {q[2i+1], q[2i], q[2i-1]}
// onto one signed digit.
module booth_r4_encoder
  import booth_pkg::*;
(
  input  logic [2:0]   win,
  output booth_digit_t digit
);

  // 111 is also a zero digit, so its sign flag is suppressed.
  assign digit.zero = (win == 3'b000) || (win == 3'b111);
  assign digit.dbl  = (win == 3'b011) || (win == 3'b100);
  assign digit.neg  = win[2] & ~(win[1] & win[0]);

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier: one recoded digit per RUN cycle, signed
// or unsigned operands through one datapath by extending both to WIDTH+2 bits.
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int EW   = WIDTH + 2;
  localparam int AW   = 2 * WIDTH;
  localparam int ITER = WIDTH / 2 + 1;
  localparam int CW   = $clog2(ITER);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [EW-1:0] m_ext;
  logic [EW:0]   q_win;   // extended Q with the implicit Q[-1]=0 appended below
  logic [AW-1:0] acc;

  booth_digit_t  digit;
  logic [AW-1:0] m_wide, mag, pp, addend, acc_sum;
  logic          last;

  booth_r4_encoder u_enc (
    .win   (q_win[2:0]),
    .digit (digit)
  );

  // Partial products are formed at full accumulator width, so -2M never loses
  // its top bit; the result is exact modulo 2^(2*WIDTH).
  assign m_wide  = {{(AW-EW){m_ext[EW-1]}}, m_ext};
  assign mag     = digit.dbl ? (m_wide << 1) : m_wide;
  assign pp      = digit.zero ? '0 : (digit.neg ? (~mag + 1'b1) : mag);
  assign addend  = pp << {cnt, 1'b0};
  assign acc_sum = acc + addend;
  assign last    = (cnt == CW'(ITER - 1));

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt     <= '0;
      acc     <= '0;
      m_ext   <= '0;
      q_win   <= '0;
      product <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (start) begin
          m_ext <= is_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand}
                             : {2'b00, multiplicand};
          q_win <= is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier, 1'b0}
                             : {2'b00, multiplier, 1'b0};
          acc   <= '0;
          cnt   <= '0;
        end
        ST_RUN: begin
          acc   <= acc_sum;
          cnt   <= cnt + 1'b1;
          q_win <= q_win >> 2;
          if (last) product <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and randomized checks of booth_mult_seq at WIDTH=32: products,
// done timing, start-ignore, clr abort and back-to-back operation.
module tb_booth_mult_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        is_signed;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int checks = 0;
  int errors = 0;

  booth_mult_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  // Edge 1 is the start-capturing edge. Optionally re-pulses start so it is
  // sampled at edge pulse_at, and asserts clr so it is sampled at edge clr_at.
  // Returns at #1 after the edge following the first done (an IDLE cycle).
  task automatic run_op(input logic s, input logic [31:0] m, input logic [31:0] q,
                        input int pulse_at, input int clr_at,
                        output int done_edge, output logic [63:0] prod,
                        output logic done_after, output logic busy_after,
                        output logic busy_clr, output logic [63:0] prod_clr);
    done_edge  = 0;
    prod       = 'x;
    done_after = 1'bx;
    busy_after = 1'bx;
    busy_clr   = 1'bx;
    prod_clr   = 'x;
    @(negedge clk);
    is_signed    = s;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      start        = (k + 1 == pulse_at);
      clr          = (k + 1 == clr_at);
      multiplicand = $urandom;
      multiplier   = $urandom;
      is_signed    = ~s;
      if (k == clr_at) begin
        busy_clr = busy;
        prod_clr = product;
      end
      if (done_edge != 0) begin
        done_after = done;
        busy_after = busy;
        break;
      end
      if (done) begin
        done_edge = k;
        prod      = product;
      end
    end
    start = 1'b0;
    clr   = 1'b0;
  endtask

  task automatic test_reset;
    clr = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (product !== 64'h0) begin errors++; $display("FAIL reset_product got %h want 0", product); end
    clr = 1'b0;
  endtask

  task automatic test_vector(input string name, input logic s, input logic [31:0] m,
                             input logic [31:0] q, input logic [63:0] exp);
    int de; logic [63:0] p, pc; logic da, ba, bc;
    run_op(s, m, q, 0, 0, de, p, da, ba, bc, pc);
    checks++; if (de !== 18) begin errors++; $display("FAIL %s_done_edge got %0d want 18", name, de); end
    checks++; if (p !== exp) begin errors++; $display("FAIL %s_product got %h want %h", name, p, exp); end
    checks++; if (da !== 1'b0 || ba !== 1'b0) begin
      errors++; $display("FAIL %s_done_once got done=%b busy=%b want 0 0", name, da, ba);
    end
    // Product must hold into the following IDLE cycle.
    checks++; if (product !== exp) begin errors++; $display("FAIL %s_hold got %h want %h", name, product, exp); end
  endtask

  task automatic test_start_ignored;
    int de; logic [63:0] p, pc; logic da, ba, bc;
    run_op(1'b0, 32'h0000FFFF, 32'h0000FFFF, 5, 0, de, p, da, ba, bc, pc);
    checks++; if (de !== 18) begin errors++; $display("FAIL start_ignored_edge got %0d want 18", de); end
    checks++; if (p !== 64'h00000000FFFE0001) begin
      errors++; $display("FAIL start_ignored_product got %h want 00000000fffe0001", p);
    end
    checks++; if (da !== 1'b0 || ba !== 1'b0) begin
      errors++; $display("FAIL start_ignored_restart got done=%b busy=%b want 0 0", da, ba);
    end
  endtask

  task automatic test_clr_abort;
    int de; logic [63:0] p, pc; logic da, ba, bc;
    run_op(1'b1, 32'h12345678, 32'h9ABCDEF0, 0, 8, de, p, da, ba, bc, pc);
    checks++; if (bc !== 1'b0) begin errors++; $display("FAIL clr_abort_busy got %b want 0", bc); end
    checks++; if (pc !== 64'h0) begin errors++; $display("FAIL clr_abort_product got %h want 0", pc); end
    checks++; if (de !== 0) begin errors++; $display("FAIL clr_abort_done got edge %0d want none", de); end
    run_op(1'b1, 32'd3, 32'hFFFFFFFB, 0, 0, de, p, da, ba, bc, pc);
    checks++; if (de !== 18) begin errors++; $display("FAIL clr_after_edge got %0d want 18", de); end
    checks++; if (p !== 64'hFFFFFFFFFFFFFFF1) begin
      errors++; $display("FAIL clr_after_product got %h want fffffffffffffff1", p);
    end
  endtask

  // Random pairs issued with start in the IDLE cycle right after each done.
  task automatic test_back_to_back;
    int de; logic [63:0] p, pc, exp; logic da, ba, bc;
    logic [31:0] m, q;
    for (int mode = 0; mode < 2; mode++) begin
      for (int n = 0; n < 300; n++) begin
        m = $urandom;
        q = $urandom;
        if (n == 0) m = 32'h80000000;
        if (n == 1) q = 32'h7FFFFFFF;
        if (mode == 1) exp = 64'(longint'(signed'(m)) * longint'(signed'(q)));
        else           exp = {32'h0, m} * {32'h0, q};
        run_op(mode[0], m, q, 0, 0, de, p, da, ba, bc, pc);
        checks++; if (de !== 18 || p !== exp) begin
          errors++;
          $display("FAIL b2b_mode%0d_%0d m=%h q=%h got %h at edge %0d want %h at 18",
                   mode, n, m, q, p, de, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vector("s_ones",    1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001);
    test_vector("u_ones",    1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
    test_vector("s_minneg",  1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000);
    test_vector("s_7xm3",    1'b1, 32'd7,        32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFEB);
    test_vector("u_msbx2",   1'b0, 32'h80000000, 32'd2,        64'h0000000100000000);
    test_vector("s_zero",    1'b1, 32'h0,        32'hDEADBEEF, 64'h0);
    test_vector("u_shift4",  1'b0, 32'h12345678, 32'h10,       64'h0000000123456780);
    test_start_ignored();
    test_clr_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
